// File: rtl/dbus_pkg.sv
// dbus_pkg: shared types and constants for the data-bus arbiter slice.
//   dbus_req_t  - one master's request bundle (address, strobes, byte enables, write data)
//   dbus_rsp_t  - response bundle routed back to the owning master
//   arb_state_e - arbiter FSM encoding
//   DBUS_ERR_DATA - read data returned when the watchdog terminates a read
package dbus_pkg;

  localparam logic [31:0] DBUS_ERR_DATA = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [31:0] addr;
    logic        rd_req;
    logic        wr_req;
    logic [3:0]  be;
    logic [31:0] wr_data;
  } dbus_req_t;

  typedef struct packed {
    logic        rd_ready;
    logic        wr_ready;
    logic [31:0] rd_data;
  } dbus_rsp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  // A master is requesting whenever either strobe is high.
  function automatic logic is_req(input dbus_req_t r);
    return r.rd_req | r.wr_req;
  endfunction

endpackage

// File: rtl/dbus_watchdog.sv
// dbus_watchdog: per-transfer stall counter.
//   clk, rstb - clock, asynchronous active-low reset
//   clear     - hold the count at zero (bus not owned)
//   enable    - one more cycle of waiting without completion
//   expire    - this enabled cycle is the TIMEOUT-th cycle of the transfer
module dbus_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rstb,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // The grant cycle sees cnt==0, so expiry lands on the TIMEOUT-th owned cycle.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expire = enable & (cnt == LAST);

endmodule

// File: rtl/dbus_arbiter.sv
// dbus_arbiter: two-master, one-slave round-robin arbiter for the data-memory port.
//   m0_* - core load/store port, m1_* - debug/DMA requester
//   s_*  - shared slave port
//   grant     - one-hot current owner, 00 when idle
//   bus_err   - one-cycle pulse when the watchdog terminates a transfer
//   dbg_state - current arbiter FSM state (arb_state_e encoding)
//
// Handshake: a master raises rd_req or wr_req (level) with addr/be/wr_data stable
// and holds it until the matching rd_ready/wr_ready is seen high in a cycle; that
// cycle completes the transfer, and rd_data is valid only while rd_ready is high.
// Dropping both strobes before ready abandons the request without a response.
module dbus_arbiter
  import dbus_pkg::*;
#(
  parameter int          TIMEOUT  = 64,
  parameter logic [31:0] ERR_DATA = DBUS_ERR_DATA
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic [31:0] m0_addr,
  input  logic        m0_rd_req,
  input  logic        m0_wr_req,
  input  logic [3:0]  m0_be,
  input  logic [31:0] m0_wr_data,
  output logic        m0_rd_ready,
  output logic        m0_wr_ready,
  output logic [31:0] m0_rd_data,
  input  logic [31:0] m1_addr,
  input  logic        m1_rd_req,
  input  logic        m1_wr_req,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_wr_data,
  output logic        m1_rd_ready,
  output logic        m1_wr_ready,
  output logic [31:0] m1_rd_data,
  output logic [31:0] s_addr,
  output logic        s_rd_req,
  output logic        s_wr_req,
  output logic [3:0]  s_be,
  output logic [31:0] s_wr_data,
  input  logic        s_rd_ready,
  input  logic        s_wr_ready,
  input  logic [31:0] s_rd_data,
  output logic [1:0]  grant,
  output logic        bus_err,
  output logic [1:0]  dbg_state
);

  arb_state_e state, state_nx;
  logic       last, last_nx;   // most recent owner that completed (1 = m1)

  dbus_req_t  req0, req1, sel;
  dbus_rsp_t  rsp;
  logic       own, sel_req, done, expire, wd_enable, wd_clear;

  assign req0 = '{addr: m0_addr, rd_req: m0_rd_req, wr_req: m0_wr_req, be: m0_be, wr_data: m0_wr_data};
  assign req1 = '{addr: m1_addr, rd_req: m1_rd_req, wr_req: m1_wr_req, be: m1_be, wr_data: m1_wr_data};

  assign own     = (state != IDLE);
  assign sel     = (state == OWN1) ? req1 : req0;
  assign sel_req = is_req(sel);

  // Either ready completes, so a master driving both strobes is still served.
  assign done = own & ((sel.rd_req & s_rd_ready) | (sel.wr_req & s_wr_ready));

  assign wd_clear  = ~own;
  assign wd_enable = own & sel_req & ~done;

  dbus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rstb   (rstb),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expire (expire)
  );

  // Slave side: owner's request forwarded combinationally; strobes are pulled
  // low in the expiry cycle so the slave never sees the abandoned access complete.
  assign s_addr    = own ? sel.addr    : '0;
  assign s_be      = own ? sel.be      : '0;
  assign s_wr_data = own ? sel.wr_data : '0;
  assign s_rd_req  = own & sel.rd_req & ~expire;
  assign s_wr_req  = own & sel.wr_req & ~expire;

  // Response toward the owner; expiry stands in for the missing slave ready.
  always_comb begin
    rsp          = '0;
    rsp.rd_ready = own & sel.rd_req & (s_rd_ready | expire);
    rsp.wr_ready = own & sel.wr_req & (s_wr_ready | expire);
    rsp.rd_data  = expire ? ERR_DATA : s_rd_data;
  end

  assign m0_rd_ready = (state == OWN0) & rsp.rd_ready;
  assign m0_wr_ready = (state == OWN0) & rsp.wr_ready;
  assign m0_rd_data  = (state == OWN0) ? rsp.rd_data : '0;
  assign m1_rd_ready = (state == OWN1) & rsp.rd_ready;
  assign m1_wr_ready = (state == OWN1) & rsp.wr_ready;
  assign m1_rd_data  = (state == OWN1) ? rsp.rd_data : '0;

  assign grant     = {state == OWN1, state == OWN0};
  assign bus_err   = expire;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= IDLE;
      last  <= 1'b1;   // m0 wins the first tie after reset
    end else begin
      state <= state_nx;
      last  <= last_nx;
    end
  end

  always_comb begin
    state_nx = state;
    last_nx  = last;
    case (state)
      IDLE: begin
        if (is_req(req0) && is_req(req1)) begin
          state_nx = last ? OWN0 : OWN1;
        end else if (is_req(req0)) begin
          state_nx = OWN0;
        end else if (is_req(req1)) begin
          state_nx = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (done | expire) begin
          state_nx = IDLE;
          last_nx  = (state == OWN1);
        end else if (!sel_req) begin
          // Master abandoned its request: release without touching round-robin order.
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

`ifndef SYNTHESIS
  // Simultaneous read and write from the owner is forwarded but flagged in simulation.
  a_single_strobe: assert property (@(posedge clk) disable iff (!rstb)
    own |-> !(sel.rd_req && sel.wr_req));
`endif

endmodule

// File: tb/tb_dbus_arbiter.sv
module tb_dbus_arbiter;

  localparam int          TMO = 4;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus state ----------------
  logic        rd[2], wr[2];
  logic [31:0] addr[2], wdat[2];
  logic [3:0]  be[2];
  logic        s_rd_ready, s_wr_ready;
  logic [31:0] s_rd_data;

  logic        m0_rd_ready, m0_wr_ready, m1_rd_ready, m1_wr_ready;
  logic [31:0] m0_rd_data, m1_rd_data;
  logic [31:0] s_addr, s_wr_data;
  logic        s_rd_req, s_wr_req;
  logic [3:0]  s_be;
  logic [1:0]  grant, dbg_state;
  logic        bus_err;

  dbus_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rstb(rstb),
    .m0_addr(addr[0]), .m0_rd_req(rd[0]), .m0_wr_req(wr[0]), .m0_be(be[0]), .m0_wr_data(wdat[0]),
    .m0_rd_ready(m0_rd_ready), .m0_wr_ready(m0_wr_ready), .m0_rd_data(m0_rd_data),
    .m1_addr(addr[1]), .m1_rd_req(rd[1]), .m1_wr_req(wr[1]), .m1_be(be[1]), .m1_wr_data(wdat[1]),
    .m1_rd_ready(m1_rd_ready), .m1_wr_ready(m1_wr_ready), .m1_rd_data(m1_rd_data),
    .s_addr(s_addr), .s_rd_req(s_rd_req), .s_wr_req(s_wr_req), .s_be(s_be), .s_wr_data(s_wr_data),
    .s_rd_ready(s_rd_ready), .s_wr_ready(s_wr_ready), .s_rd_data(s_rd_data),
    .grant(grant), .bus_err(bus_err), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: owner index (-1 idle), cycles already spent owning, last completed owner.
  int own_m, age_m, last_m;
  int own_nx, age_nx, last_nx;

  function automatic logic rq(input int m);
    return rd[m] | wr[m];
  endfunction

  task automatic model_reset();
    own_m = -1; age_m = 0; last_m = 1;
    own_nx = -1; age_nx = 0; last_nx = 1;
  endtask

  task automatic model_check();
    logic r, w, cmp, tmo, e_err, e_srr, e_swr;
    logic [1:0]  e_grant;
    logic [3:0]  e_rdy;   // {m1 wr, m1 rd, m0 wr, m0 rd}
    logic [31:0] e_addr, e_wd, e_be, e_rd0, e_rd1, rdv;
    r = 1'b0; w = 1'b0; cmp = 1'b0; tmo = 1'b0; e_err = 1'b0; e_srr = 1'b0; e_swr = 1'b0;
    e_grant = '0; e_rdy = '0; e_addr = '0; e_wd = '0; e_be = '0; e_rd0 = '0; e_rd1 = '0;
    own_nx = own_m; age_nx = age_m; last_nx = last_m;
    if (!rstb) begin
      own_nx = -1; age_nx = 0; last_nx = 1;
    end else if (own_m < 0) begin
      if (rq(0) && rq(1)) own_nx = (last_m == 1) ? 0 : 1;
      else if (rq(0))     own_nx = 0;
      else if (rq(1))     own_nx = 1;
      age_nx = 0;
    end else begin
      r   = rd[own_m];
      w   = wr[own_m];
      cmp = (r && s_rd_ready) || (w && s_wr_ready);
      tmo = !cmp && (r || w) && (age_m == TMO - 1);
      e_grant = (own_m == 0) ? 2'b01 : 2'b10;
      e_err = tmo; e_srr = r && !tmo; e_swr = w && !tmo;
      e_addr = addr[own_m]; e_wd = wdat[own_m]; e_be = {28'd0, be[own_m]};
      rdv = tmo ? ERR : s_rd_data;
      if (own_m == 0) begin
        e_rdy[0] = r && (s_rd_ready || tmo);
        e_rdy[1] = w && (s_wr_ready || tmo);
        e_rd0 = rdv;
      end else begin
        e_rdy[2] = r && (s_rd_ready || tmo);
        e_rdy[3] = w && (s_wr_ready || tmo);
        e_rd1 = rdv;
      end
      if (cmp || tmo) begin
        own_nx = -1; last_nx = own_m;
      end else if (!(r || w)) begin
        own_nx = -1;
      end else begin
        age_nx = age_m + 1;
      end
    end
    exp_q.push_back({23'd0, e_grant, e_err, e_srr, e_swr, e_rdy});
    exp_q.push_back(e_addr);
    exp_q.push_back(e_be);
    exp_q.push_back(e_wd);
    exp_q.push_back(e_rd0);
    exp_q.push_back(e_rd1);
    check("ctl", {23'd0, grant, bus_err, s_rd_req, s_wr_req, m1_wr_ready, m1_rd_ready, m0_wr_ready, m0_rd_ready}, exp_q.pop_front());
    check("s_addr", s_addr, exp_q.pop_front());
    check("s_be", {28'd0, s_be}, exp_q.pop_front());
    check("s_wr_data", s_wr_data, exp_q.pop_front());
    check("m0_rd_data", m0_rd_data, exp_q.pop_front());
    check("m1_rd_data", m1_rd_data, exp_q.pop_front());
  endtask

  task automatic model_commit();
    if (!rstb) model_reset();
    else begin
      own_m = own_nx; age_m = age_nx; last_m = last_nx;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic sample();
    @(negedge clk);
    model_check();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    model_commit();
  endtask

  task automatic drive_m(input int m, input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b);
    rd[m] = r; wr[m] = w; addr[m] = a; wdat[m] = d; be[m] = b;
  endtask

  task automatic drive_s(input logic rr, input logic wrr, input logic [31:0] d);
    s_rd_ready = rr; s_wr_ready = wrr; s_rd_data = d;
  endtask

  task automatic idle_all();
    drive_m(0, 1'b0, 1'b0, '0, '0, '0);
    drive_m(1, 1'b0, 1'b0, '0, '0, '0);
    drive_s(1'b0, 1'b0, '0);
  endtask

  task automatic do_reset();
    idle_all();
    rstb = 1'b0;
    #1;
    model_reset();
    repeat (2) begin sample(); adv(); end
    rstb = 1'b1;
  endtask

  task automatic rand_master(input int m, input logic seen_done);
    logic pend;
    pend = rq(m);
    if (pend && seen_done) begin
      drive_m(m, 1'b0, 1'b0, addr[m], wdat[m], be[m]);
      pend = 1'b0;
      if ($urandom_range(0, 99) < 40) begin
        if ($urandom_range(0, 1) == 1) drive_m(m, 1'b1, 1'b0, $urandom, $urandom, 4'($urandom_range(0, 15)));
        else                           drive_m(m, 1'b0, 1'b1, $urandom, $urandom, 4'($urandom_range(0, 15)));
      end
    end else if (pend) begin
      if ($urandom_range(0, 99) < 3) drive_m(m, 1'b0, 1'b0, addr[m], wdat[m], be[m]);
    end else if ($urandom_range(0, 99) < 30) begin
      if ($urandom_range(0, 1) == 1) drive_m(m, 1'b1, 1'b0, $urandom, $urandom, 4'($urandom_range(0, 15)));
      else                           drive_m(m, 1'b0, 1'b1, $urandom, $urandom, 4'($urandom_range(0, 15)));
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int m0_done, m1_at;
    logic m1_fin, d0, d1;
    idle_all();
    model_reset();
    rstb = 1'b0;
    repeat (3) begin sample(); adv(); end
    check("rst_grant", {30'd0, grant}, 32'd0);
    check("rst_s_req", {30'd0, s_rd_req, s_wr_req}, 32'd0);
    check("rst_err", {31'd0, bus_err}, 32'd0);
    rstb = 1'b1;

    // single read, zero-wait slave
    drive_m(0, 1'b1, 1'b0, 32'h100, '0, 4'hF);
    drive_s(1'b1, 1'b0, 32'h1234_5678);
    sample(); check("sr_req_cycle_grant", {30'd0, grant}, 32'd0); adv();
    sample();
    check("sr_grant", {30'd0, grant}, 32'd1);
    check("sr_m0_rdy", {31'd0, m0_rd_ready}, 32'd1);
    check("sr_m0_data", m0_rd_data, 32'h1234_5678);
    check("sr_m1_rdy", {31'd0, m1_rd_ready}, 32'd0);
    check("sr_s_addr", s_addr, 32'h100);
    adv();
    drive_m(0, 1'b0, 1'b0, '0, '0, '0);
    sample(); check("sr_idle_ignore", {31'd0, m0_rd_ready}, 32'd0); adv();
    drive_s(1'b0, 1'b0, '0);

    // tie after reset: m0 first, m1 two cycles after m0 completes
    do_reset();
    drive_m(0, 1'b0, 1'b1, 32'h200, 32'hA0A0_A0A0, 4'hF);
    drive_m(1, 1'b0, 1'b1, 32'h300, 32'hB1B1_B1B1, 4'h3);
    drive_s(1'b0, 1'b1, '0);
    sample(); adv();
    sample();
    check("tie_g1", {30'd0, grant}, 32'd1);
    check("tie_m0_wr_rdy", {31'd0, m0_wr_ready}, 32'd1);
    check("tie_m1_wr_rdy0", {31'd0, m1_wr_ready}, 32'd0);
    check("tie_wd0", s_wr_data, 32'hA0A0_A0A0);
    adv();
    drive_m(0, 1'b0, 1'b0, '0, '0, '0);
    sample(); check("tie_idle", {30'd0, grant}, 32'd0); adv();
    sample();
    check("tie_g2", {30'd0, grant}, 32'd2);
    check("tie_m1_wr_rdy", {31'd0, m1_wr_ready}, 32'd1);
    check("tie_be1", {28'd0, s_be}, 32'd3);
    adv();
    idle_all();
    sample(); adv();

    // m0 read, then a tie goes to m1
    drive_m(0, 1'b1, 1'b0, 32'h104, '0, 4'hF);
    drive_s(1'b1, 1'b0, 32'h55AA_55AA);
    sample(); adv();
    sample(); check("pre_g", {30'd0, grant}, 32'd1); adv();
    drive_m(0, 1'b0, 1'b0, '0, '0, '0);
    sample(); adv();
    drive_m(0, 1'b1, 1'b0, 32'h108, '0, 4'hF);
    drive_m(1, 1'b1, 1'b0, 32'h10C, '0, 4'hF);
    drive_s(1'b1, 1'b0, 32'h0BAD_F00D);
    sample(); adv();
    sample();
    check("rtie_g", {30'd0, grant}, 32'd2);
    check("rtie_m1_rdy", {31'd0, m1_rd_ready}, 32'd1);
    check("rtie_m1_data", m1_rd_data, 32'h0BAD_F00D);
    check("rtie_m0_data", m0_rd_data, 32'd0);
    adv();
    drive_m(1, 1'b0, 1'b0, '0, '0, '0);
    sample(); check("rtie_idle", {30'd0, grant}, 32'd0); adv();
    sample(); check("rtie_g2", {30'd0, grant}, 32'd1); adv();
    idle_all();
    sample(); adv();

    // starvation: m0 streams writes, m1 read pending
    drive_m(0, 1'b0, 1'b1, 32'h400, 32'h1, 4'hF);
    drive_s(1'b1, 1'b1, 32'h77);
    sample(); adv();
    drive_m(1, 1'b1, 1'b0, 32'h500, '0, 4'hF);
    m0_done = 0; m1_at = -1;
    for (int cyc = 0; cyc < 80 && m0_done < 10; cyc++) begin
      sample();
      if (grant == 2'b10 && m1_at < 0) m1_at = m0_done;
      m1_fin = m1_rd_ready;
      if (m0_wr_ready) m0_done++;
      adv();
      if (m1_fin) drive_m(1, 1'b0, 1'b0, '0, '0, '0);
      wdat[0] = 32'(m0_done);
    end
    check("starv_m1_after", 32'(m1_at), 32'd1);
    check("starv_m0_count", 32'(m0_done), 32'd10);
    idle_all();
    sample(); adv();

    // watchdog on m1 read, slave never ready
    drive_m(1, 1'b1, 1'b0, 32'h600, '0, 4'hF);
    drive_s(1'b0, 1'b0, 32'h99);
    sample(); adv();
    for (int i = 0; i < TMO - 1; i++) begin
      sample();
      check("tmo_wait_err", {31'd0, bus_err}, 32'd0);
      check("tmo_wait_rdy", {31'd0, m1_rd_ready}, 32'd0);
      check("tmo_wait_srd", {31'd0, s_rd_req}, 32'd1);
      adv();
    end
    sample();
    check("tmo_rdy", {31'd0, m1_rd_ready}, 32'd1);
    check("tmo_data", m1_rd_data, ERR);
    check("tmo_err", {31'd0, bus_err}, 32'd1);
    check("tmo_srd", {31'd0, s_rd_req}, 32'd0);
    adv();
    drive_m(1, 1'b0, 1'b0, '0, '0, '0);
    sample(); check("tmo_idle", {30'd0, grant}, 32'd0); adv();

    // master abort
    drive_m(0, 1'b1, 1'b0, 32'h700, '0, 4'hF);
    sample(); adv();
    sample(); check("ab_g1", {30'd0, grant}, 32'd1); adv();
    drive_m(0, 1'b0, 1'b0, '0, '0, '0);
    sample();
    check("ab_rdy", {31'd0, m0_rd_ready}, 32'd0);
    check("ab_err", {31'd0, bus_err}, 32'd0);
    adv();
    sample();
    check("ab_idle", {30'd0, grant}, 32'd0);
    check("ab_err2", {31'd0, bus_err}, 32'd0);
    adv();

    // reset mid-transfer
    drive_m(1, 1'b0, 1'b1, 32'h800, 32'hCAFE, 4'hF);
    drive_s(1'b0, 1'b0, '0);
    sample(); adv();
    sample(); check("rm_g", {30'd0, grant}, 32'd2); adv();
    rstb = 1'b0;
    #1;
    model_reset();
    check("rm_grant0", {30'd0, grant}, 32'd0);
    check("rm_swr0", {31'd0, s_wr_req}, 32'd0);
    check("rm_addr0", s_addr, 32'd0);
    drive_m(0, 1'b0, 1'b1, 32'h900, 32'hF00D, 4'hF);
    sample(); adv();
    rstb = 1'b1;
    sample(); adv();
    sample(); check("rm_tie_m0", {30'd0, grant}, 32'd1); adv();
    idle_all();
    repeat (2) begin sample(); adv(); end

    // randomized traffic against the model
    d0 = 1'b0; d1 = 1'b0;
    for (int cyc = 0; cyc < 2500; cyc++) begin
      rand_master(0, d0);
      rand_master(1, d1);
      drive_s($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 55, $urandom);
      sample();
      d0 = m0_rd_ready | m0_wr_ready;
      d1 = m1_rd_ready | m1_wr_ready;
      adv();
    end
    idle_all();
    repeat (2) begin sample(); adv(); end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL time_limit: got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/dbus_arbiter.md
# dbus_arbiter

Two-master, one-slave arbiter for the data-memory port. It shares a single slave data bus (RAM or peripheral fabric) between the core's load/store port (master 0) and a debug/DMA requester (master 1). Arbitration is round-robin with a one-cycle arbitration latency. A per-transfer watchdog terminates any access the slave never acknowledges, so a stuck slave cannot stall the core forever.

## Interface
- `TIMEOUT`, default 64: cycles a granted transfer may wait for slave ready before forced termination (≥2).
- `ERR_DATA`, default 32'hDEAD_BEEF: read data returned on a timed-out read.
- `clk` in 1: clock.
- `rstb` in 1: reset, asynchronous, active-low.
- `m0_addr`, `m1_addr` in 32: master byte address.
- `m0_rd_req`, `m1_rd_req` in 1: read request, level, held until ready.
- `m0_wr_req`, `m1_wr_req` in 1: write request, level, held until ready.
- `m0_be`, `m1_be` in 4: byte enables.
- `m0_wr_data`, `m1_wr_data` in 32: write data.
- `m0_rd_ready`, `m1_rd_ready` out 1: read acknowledge; read data valid this cycle.
- `m0_wr_ready`, `m1_wr_ready` out 1: write acknowledge.
- `m0_rd_data`, `m1_rd_data` out 32: read data.
- `s_addr` out 32, `s_rd_req` out 1, `s_wr_req` out 1, `s_be` out 4, `s_wr_data` out 32: slave request side.
- `s_rd_ready` in 1, `s_wr_ready` in 1, `s_rd_data` in 32: slave response.
- `grant` out 2: one-hot current owner; 2'b00 when idle.
- `bus_err` out 1: one-cycle pulse on watchdog termination.

## Operation
- FSM states: IDLE, OWN0, OWN1. Registered state `last` holds the most recent owner for round-robin.
- A master is requesting when `rd_req|wr_req`.
- **IDLE**:
  - One requester: grant it.
  - Both requesting: grant the master that is not `last`.
  - After reset `last`=1, so m0 wins the first tie.
- **OWNn**:
  - `s_*` request outputs = master n's inputs, combinationally.
  - Slave `rd_ready`/`wr_ready`/`rd_data` route only to master n. The other master sees ready=0 and rd_data=0.
  - Transfer completes on `(s_rd_req&s_rd_ready)|(s_wr_req&s_wr_ready)`. Next state is IDLE and `last`←n.
- **Master abort**: master n drops both requests before ready. Next state IDLE, `last` unchanged, no ready or err generated.
- **Watchdog**:
  - Counter clears on entry to OWNn and increments each OWNn cycle without completion.
  - At count==TIMEOUT-1 without completion:
    - Assert master n's ready (rd or wr, matching its request) and force `s_rd_req`/`s_wr_req` to 0 that cycle.
    - Return ERR_DATA on the read data path.
    - Pulse `bus_err`; next state IDLE; `last`←n.
- **Both rd_req and wr_req from one master**: forwarded unchanged. A simulation-only assertion flags it. Completion accepts either ready.
- **Slave ready while IDLE**: ignored and never routed.
- **Reset mid-transfer**: state→IDLE, counter→0, `last`→1. The in-flight slave request drops immediately (asynchronous).

## Timing
- Reset values: all `s_*` outputs 0, all master ready 0, master rd_data 0, `grant`=0, `bus_err`=0.
- Arbitration latency:
  - Master req rises in cycle C (IDLE) → `grant` and `s_*_req` asserted in C+1.
  - Zero-wait slave → master ready in C+1.
- Back-to-back:
  - Completion in cycle K → IDLE in K+1 → next grant in K+2.
  - A master holding req continuously (core consecutive stores) re-arbitrates in K+1, so a waiting other master gets K+2.
- Ready-to-master is combinational from slave ready. There is no added response latency.
- Watchdog: forced ready occurs exactly TIMEOUT cycles after grant (grant cycle counts as 1).
- `bus_err` is registered-free: it is asserted in the same cycle as the forced ready.

## Structure
- Shared package `dbus_pkg`:
  - typedef `dbus_req_t` {addr[31:0], rd_req, wr_req, be[3:0], wr_data[31:0]}.
  - typedef `dbus_rsp_t` {rd_ready, wr_ready, rd_data[31:0]}.
  - FSM enum `arb_state_e` {IDLE, OWN0, OWN1}.
  - constant DBUS_ERR_DATA.
- Sub-module `dbus_watchdog`: counter with clear/enable, parameter TIMEOUT, output `expire`. Everything else stays in `dbus_arbiter`.

## Test plan
- **Single read**: m0 rd_req, addr=0x100; slave ready same cycle with data 0x12345678 → `grant`=01 and m0_rd_ready=1 with m0_rd_data=0x12345678 one cycle after req; m1 ready stays 0.
- **Tie after reset**: m0 and m1 both write in the same cycle → m0 served first, m1 granted two cycles after m0 completion. Repeat tie → m1 first (alternation).
- **Starvation**: m0 holds wr_req continuously for 10 transfers while m1 rd_req is pending → m1 granted no later than after m0's first completion.
- **Timeout**: TIMEOUT=4, slave never ready, m1 read → m1_rd_ready=1 with 0xDEADBEEF and `bus_err`=1 exactly 4 cycles after grant; `s_rd_req`=0 that cycle; IDLE next.
- **Abort**: m0 drops rd_req on the 2nd grant cycle with no slave ready → `grant`=00 next cycle, no ready pulse, no `bus_err`.
- **Reset mid-transfer**: assert rstb=0 while in OWN1 with slave stalled → all outputs 0 immediately. After release, a tie grants m0.
